text_write_arbiter: RTL and testbench
=====================================

Name: text_write_arbiter

Overview:
- Owns the text-buffer write port of the VGA text-mode block (wr_start / wr_begin / wr_end / wr_data / wr_offset / wr_complete).
- Shares that port between two requesters: A = escape-sequence parser, B = auxiliary writer (status line, keyboard echo).
- Sequences the multi-step scroll (copy rows up, then blank the last row) internally, so requesters never drive the engine directly.
- Sits between the terminal control logic and vga_text_mode.

Parameters:
- COLS, 80, characters per row.
- ROWS, 25, rows on screen.
- AW, 11, cell address width; COLS*ROWS must be < 2**AW.

Ports:
- clk100  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  requester A command valid; held with its fields until a_ack.
- a_op  in  2  0=FILL, 1=COPY, 2=SCROLL, 3=NOP.
- a_begin  in  AW  first cell, inclusive.
- a_end  in  AW  last cell, exclusive.
- a_data  in  8  fill character (FILL only).
- a_offset  in  8  source distance for COPY: src = dst + offset.
- a_ack  out  1  one-cycle pulse; command accepted, fields may change.
- b_req, b_op, b_begin, b_end, b_data, b_offset, b_ack: same as A, for requester B.
- wr_start  out  1  one-cycle engine start pulse.
- wr_begin  out  AW  engine range start.
- wr_end  out  AW  engine range end.
- wr_data  out  8  engine fill character.
- wr_offset  out  8  engine copy offset; 0 = fill.
- wr_complete  in  1  one-cycle pulse from the engine when the range is finished.
- busy  out  1  high from grant until the final wr_complete of the command.

Behaviour:
- Reset values: wr_start=0, wr_begin=0, wr_end=0, wr_data=0, wr_offset=0, a_ack=0, b_ack=0, busy=0; state=IDLE; last_grant=B, so A wins the first tie.
- States: IDLE, ISSUE, WAIT, CLR_ISSUE, CLR_WAIT.
- IDLE, arbitration:
  - Only one requester asserted: grant it.
  - Both asserted: grant the requester that is not last_grant (round-robin).
  - On grant: latch op and fields, update last_grant, set busy=1, go to ISSUE. No ack in this cycle.
- ISSUE (one cycle): pulse the granted ack.
  - FILL: drive wr_begin/wr_end, wr_data=fill character, wr_offset=0; pulse wr_start; go to WAIT.
  - COPY: drive wr_begin/wr_end, wr_offset=offset, wr_data=0; pulse wr_start; go to WAIT.
    - If offset=0, treat as FILL with data 0.
  - SCROLL: begin=0, end=(ROWS-1)*COLS, offset=COLS; pulse wr_start; go to WAIT. The requester's begin/end are ignored.
  - NOP: no wr_start; busy=0; go to IDLE.
  - Empty range (begin >= end, after clamping): no wr_start; busy=0; go to IDLE.
- Clamping: end > COLS*ROWS is clamped to COLS*ROWS before the empty-range check.
- WAIT: on wr_complete:
  - SCROLL: go to CLR_ISSUE.
  - Otherwise: busy=0, go to IDLE.
- CLR_ISSUE: begin=(ROWS-1)*COLS, end=ROWS*COLS, data=0, offset=0; pulse wr_start; go to CLR_WAIT.
- CLR_WAIT: on wr_complete: busy=0, go to IDLE.
- Timing:
  - Grant at cycle N -> ack and wr_start at N+1.
  - Earliest next grant: the cycle after the final wr_complete.
- Output hold: wr_* fields stay stable from wr_start until the next wr_start.
- Engine protocol: at most one wr_start outstanding at any time.
- Spurious input: wr_complete seen in IDLE or ISSUE is ignored.
- A request deasserted before its ack is a protocol violation; behaviour is undefined, no recovery required.
- Reset mid-operation: return to IDLE with all outputs at reset values. A late wr_complete from the aborted operation lands in IDLE and is ignored.
- Simultaneous request and completion: a request asserted in the same cycle as the final wr_complete is granted on the next cycle, not the same cycle.

Test Plan:
- A FILL begin=160, end=240, data=0x41 -> a_ack and wr_start one cycle after grant; wr_begin=160, wr_end=240, wr_data=0x41, wr_offset=0; busy falls the cycle wr_complete is returned.
- A and B both request after reset -> A granted first; after its wr_complete, B granted; with both held continuously, grants alternate A, B, A.
- B SCROLL -> first wr_start with 0/1920/offset 80; after wr_complete, second wr_start with 1920/2000/data 0/offset 0; b_ack pulses exactly once; busy stays high through both.
- A FILL begin=100, end=100; then NOP; then end=2047 -> first two: ack, no wr_start, busy low within 2 cycles; third: wr_end=2000.
- Reset asserted in WAIT, then wr_complete pulsed -> all outputs 0, state IDLE, no wr_start generated; next request serviced normally.
- wr_complete pulsed while IDLE with no requests -> no ack, no wr_start, busy stays 0.

Source files
------------

// File: rtl/text_write_arbiter.sv
// Shares the text-buffer write engine between the escape parser (A) and an auxiliary writer (B),
// and runs the two-step scroll (copy rows up, then blank the last row) internally.
module text_write_arbiter #(
    parameter int unsigned COLS = 80,
    parameter int unsigned ROWS = 25,
    parameter int unsigned AW   = 11
) (
    input  logic          clk100,
    input  logic          rst,

    input  logic          a_req,
    input  logic [1:0]    a_op,
    input  logic [AW-1:0] a_begin,
    input  logic [AW-1:0] a_end,
    input  logic [7:0]    a_data,
    input  logic [7:0]    a_offset,
    output logic          a_ack,

    input  logic          b_req,
    input  logic [1:0]    b_op,
    input  logic [AW-1:0] b_begin,
    input  logic [AW-1:0] b_end,
    input  logic [7:0]    b_data,
    input  logic [7:0]    b_offset,
    output logic          b_ack,

    output logic          wr_start,
    output logic [AW-1:0] wr_begin,
    output logic [AW-1:0] wr_end,
    output logic [7:0]    wr_data,
    output logic [7:0]    wr_offset,
    input  logic          wr_complete,

    output logic          busy
);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StClrIssue,
        StClrWait
    } state_e;

    localparam logic [1:0] OpFill   = 2'd0;
    localparam logic [1:0] OpCopy   = 2'd1;
    localparam logic [1:0] OpScroll = 2'd2;
    localparam logic [1:0] OpNop    = 2'd3;

    localparam logic [AW-1:0] Cells   = AW'(COLS * ROWS);
    localparam logic [AW-1:0] LastRow = AW'((ROWS - 1) * COLS);
    localparam logic [7:0]    ColsOff = 8'(COLS);

    state_e        state_q;
    logic          last_grant_b_q;
    logic          cmd_b_q;
    logic [1:0]    op_q;
    logic [AW-1:0] begin_q;
    logic [AW-1:0] end_q;
    logic [7:0]    data_q;
    logic [7:0]    offset_q;

    logic          grant_b;
    logic [AW-1:0] end_clamped;
    logic          range_empty;

    // On a tie, the requester that did not win last time goes next.
    always_comb begin
        grant_b     = b_req && (!a_req || !last_grant_b_q);
        end_clamped = (end_q > Cells) ? Cells : end_q;
        range_empty = (begin_q >= end_clamped);
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            state_q        <= StIdle;
            last_grant_b_q <= 1'b1;
            cmd_b_q        <= 1'b0;
            op_q           <= OpNop;
            begin_q        <= '0;
            end_q          <= '0;
            data_q         <= '0;
            offset_q       <= '0;
            a_ack          <= 1'b0;
            b_ack          <= 1'b0;
            wr_start       <= 1'b0;
            wr_begin       <= '0;
            wr_end         <= '0;
            wr_data        <= '0;
            wr_offset      <= '0;
            busy           <= 1'b0;
        end else begin
            a_ack    <= 1'b0;
            b_ack    <= 1'b0;
            wr_start <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (a_req || b_req) begin
                        cmd_b_q        <= grant_b;
                        last_grant_b_q <= grant_b;
                        op_q           <= grant_b ? b_op     : a_op;
                        begin_q        <= grant_b ? b_begin  : a_begin;
                        end_q          <= grant_b ? b_end    : a_end;
                        data_q         <= grant_b ? b_data   : a_data;
                        offset_q       <= grant_b ? b_offset : a_offset;
                        busy           <= 1'b1;
                        state_q        <= StIssue;
                    end
                end

                StIssue: begin
                    a_ack <= !cmd_b_q;
                    b_ack <= cmd_b_q;
                    if (op_q == OpScroll) begin
                        wr_begin  <= '0;
                        wr_end    <= LastRow;
                        wr_data   <= 8'd0;
                        wr_offset <= ColsOff;
                        wr_start  <= 1'b1;
                        state_q   <= StWait;
                    end else if (op_q == OpNop || range_empty) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        // A copy with zero offset degenerates to a fill with blanks.
                        wr_begin  <= begin_q;
                        wr_end    <= end_clamped;
                        wr_data   <= (op_q == OpFill) ? data_q : 8'd0;
                        wr_offset <= (op_q == OpCopy) ? offset_q : 8'd0;
                        wr_start  <= 1'b1;
                        state_q   <= StWait;
                    end
                end

                StWait: begin
                    if (wr_complete) begin
                        if (op_q == OpScroll) begin
                            state_q <= StClrIssue;
                        end else begin
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end

                StClrIssue: begin
                    wr_begin  <= LastRow;
                    wr_end    <= Cells;
                    wr_data   <= 8'd0;
                    wr_offset <= 8'd0;
                    wr_start  <= 1'b1;
                    state_q   <= StClrWait;
                end

                StClrWait: begin
                    if (wr_complete) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_text_write_arbiter.sv
// Directed bench for text_write_arbiter: a vector table of single commands plus hand-written
// sequences for arbitration, scroll, reset mid-operation and spurious completions.
module tb_text_write_arbiter;

    logic        clk100 = 1'b0;
    logic        rst;
    logic        a_req, b_req;
    logic [1:0]  a_op, b_op;
    logic [10:0] a_begin, a_end, b_begin, b_end;
    logic [7:0]  a_data, a_offset, b_data, b_offset;
    logic        a_ack, b_ack;
    logic        wr_start;
    logic [10:0] wr_begin, wr_end;
    logic [7:0]  wr_data, wr_offset;
    logic        wr_complete;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    int b_ack_cnt = 0;
    int start_cnt = 0;
    logic [63:0] exp_hold = '0;

    text_write_arbiter #(.COLS(80), .ROWS(25), .AW(11)) dut (
        .clk100     (clk100),
        .rst        (rst),
        .a_req      (a_req),
        .a_op       (a_op),
        .a_begin    (a_begin),
        .a_end      (a_end),
        .a_data     (a_data),
        .a_offset   (a_offset),
        .a_ack      (a_ack),
        .b_req      (b_req),
        .b_op       (b_op),
        .b_begin    (b_begin),
        .b_end      (b_end),
        .b_data     (b_data),
        .b_offset   (b_offset),
        .b_ack      (b_ack),
        .wr_start   (wr_start),
        .wr_begin   (wr_begin),
        .wr_end     (wr_end),
        .wr_data    (wr_data),
        .wr_offset  (wr_offset),
        .wr_complete(wr_complete),
        .busy       (busy)
    );

    always #5 clk100 = ~clk100;

    // Pulse counters, sampled well after the edge so they never race the checks at negedge.
    always begin
        @(posedge clk100);
        #2;
        if (b_ack) b_ack_cnt++;
        if (wr_start) start_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic        use_b;
        logic [1:0]  op;
        logic [10:0] bg;
        logic [10:0] en;
        logic [7:0]  dat;
        logic [7:0]  off;
        logic        exp_start;
        logic [10:0] ebg;
        logic [10:0] een;
        logic [7:0]  edat;
        logic [7:0]  eoff;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] fields();
        return 64'({wr_begin, wr_end, wr_data, wr_offset});
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({a_ack, b_ack, busy, wr_start, wr_begin, wr_end, wr_data, wr_offset});
    endfunction

    task automatic run_cmd(input vec_t v, input string tag);
        int i;
        logic got;
        logic [63:0] want;
        @(negedge clk100);
        if (v.use_b) begin
            b_req = 1'b1; b_op = v.op; b_begin = v.bg; b_end = v.en; b_data = v.dat;
            b_offset = v.off;
        end else begin
            a_req = 1'b1; a_op = v.op; a_begin = v.bg; a_end = v.en; a_data = v.dat;
            a_offset = v.off;
        end
        got = 1'b0;
        for (i = 0; i < 10; i++) begin
            @(negedge clk100);
            if (v.use_b ? b_ack : a_ack) begin
                got = 1'b1;
                break;
            end
        end
        chk($sformatf("%s ack_latency", tag), 64'(i), 64'd1);
        if (!got) begin
            a_req = 1'b0;
            b_req = 1'b0;
            return;
        end
        chk($sformatf("%s other_ack", tag), 64'(v.use_b ? a_ack : b_ack), 64'd0);
        chk($sformatf("%s wr_start", tag), 64'(wr_start), 64'(v.exp_start));
        if (v.exp_start) exp_hold = 64'({v.ebg, v.een, v.edat, v.eoff});
        want = exp_hold;
        chk($sformatf("%s fields", tag), fields(), want);
        a_req = 1'b0;
        b_req = 1'b0;
        @(negedge clk100);
        chk($sformatf("%s single_pulse", tag), 64'({a_ack, b_ack, wr_start}), 64'd0);
        chk($sformatf("%s busy", tag), 64'(busy), 64'(v.exp_start));
        if (v.exp_start) begin
            wr_complete = 1'b1;
            @(negedge clk100);
            wr_complete = 1'b0;
            chk($sformatf("%s busy_fall", tag), 64'(busy), 64'd0);
        end
    endtask

    initial begin
        int i;
        int snap;
        logic got;
        vec_t v;

        vecs[0]  = '{1'b0, 2'd0, 11'd160,  11'd240,  8'h41, 8'h00, 1'b1, 11'd160,  11'd240,  8'h41, 8'h00};
        vecs[1]  = '{1'b0, 2'd1, 11'd0,    11'd1000, 8'h55, 8'h05, 1'b1, 11'd0,    11'd1000, 8'h00, 8'h05};
        vecs[2]  = '{1'b0, 2'd1, 11'd10,   11'd20,   8'h33, 8'h00, 1'b1, 11'd10,   11'd20,   8'h00, 8'h00};
        vecs[3]  = '{1'b0, 2'd0, 11'd100,  11'd100,  8'h41, 8'h00, 1'b0, 11'd0,    11'd0,    8'h00, 8'h00};
        vecs[4]  = '{1'b0, 2'd3, 11'd0,    11'd50,   8'h41, 8'h00, 1'b0, 11'd0,    11'd0,    8'h00, 8'h00};
        vecs[5]  = '{1'b0, 2'd0, 11'd100,  11'd2047, 8'h20, 8'h00, 1'b1, 11'd100,  11'd2000, 8'h20, 8'h00};
        vecs[6]  = '{1'b0, 2'd1, 11'd1999, 11'd2047, 8'h00, 8'h09, 1'b1, 11'd1999, 11'd2000, 8'h00, 8'h09};
        vecs[7]  = '{1'b0, 2'd0, 11'd2000, 11'd2047, 8'h41, 8'h00, 1'b0, 11'd0,    11'd0,    8'h00, 8'h00};
        vecs[8]  = '{1'b0, 2'd0, 11'd50,   11'd10,   8'h41, 8'h00, 1'b0, 11'd0,    11'd0,    8'h00, 8'h00};
        vecs[9]  = '{1'b1, 2'd0, 11'd5,    11'd6,    8'h7e, 8'h00, 1'b1, 11'd5,    11'd6,    8'h7e, 8'h00};
        vecs[10] = '{1'b1, 2'd1, 11'd1500, 11'd1600, 8'h00, 8'd80, 1'b1, 11'd1500, 11'd1600, 8'h00, 8'd80};

        rst = 1'b1;
        a_req = 1'b0; a_op = 2'd0; a_begin = '0; a_end = '0; a_data = '0; a_offset = '0;
        b_req = 1'b0; b_op = 2'd0; b_begin = '0; b_end = '0; b_data = '0; b_offset = '0;
        wr_complete = 1'b0;
        repeat (3) @(negedge clk100);
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b0;

        // Completion while idle must be ignored.
        snap = start_cnt;
        wr_complete = 1'b1;
        @(negedge clk100);
        wr_complete = 1'b0;
        repeat (2) @(negedge clk100);
        chk("spurious_idle", all_outs(), 64'd0);
        chk("spurious_no_start", 64'(start_cnt - snap), 64'd0);

        // Both held continuously: A, B, A.
        @(negedge clk100);
        a_req = 1'b1; a_op = 2'd0; a_begin = 11'd0;  a_end = 11'd10; a_data = 8'h61;
        b_req = 1'b1; b_op = 2'd0; b_begin = 11'd20; b_end = 11'd30; b_data = 8'h62;
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (i = 0; i < 10; i++) begin
                @(negedge clk100);
                if (a_ack || b_ack) begin
                    got = 1'b1;
                    break;
                end
            end
            chk($sformatf("arb%0d ack_latency", k), 64'(i), 64'd1);
            chk($sformatf("arb%0d winner", k), 64'({a_ack, b_ack}),
                (k == 1) ? 64'b01 : 64'b10);
            exp_hold = (k == 1) ? 64'({11'd20, 11'd30, 8'h62, 8'h00})
                                : 64'({11'd0, 11'd10, 8'h61, 8'h00});
            chk($sformatf("arb%0d fields", k), fields(), exp_hold);
            if (k == 2 || !got) begin
                a_req = 1'b0;
                b_req = 1'b0;
            end
            @(negedge clk100);
            wr_complete = 1'b1;
            @(negedge clk100);
            wr_complete = 1'b0;
        end
        @(negedge clk100);
        chk("arb idle_after", 64'(busy), 64'd0);

        for (int n = 0; n < 11; n++) run_cmd(vecs[n], $sformatf("vec%0d", n));

        // Scroll issued by B: copy rows up, then clear the last row.
        snap = b_ack_cnt;
        @(negedge clk100);
        b_req = 1'b1; b_op = 2'd2; b_begin = 11'd7; b_end = 11'd9; b_data = 8'h55;
        b_offset = 8'd3;
        for (i = 0; i < 10; i++) begin
            @(negedge clk100);
            if (b_ack) break;
        end
        chk("scroll ack_latency", 64'(i), 64'd1);
        chk("scroll copy", 64'({wr_start, wr_begin, wr_end, wr_offset}),
            64'({1'b1, 11'd0, 11'd1920, 8'd80}));
        b_req = 1'b0;
        @(negedge clk100);
        chk("scroll busy1", 64'(busy), 64'd1);
        wr_complete = 1'b1;
        @(negedge clk100);
        wr_complete = 1'b0;
        chk("scroll busy2", 64'(busy), 64'd1);
        for (i = 0; i < 10; i++) begin
            if (wr_start) break;
            @(negedge clk100);
        end
        chk("scroll clr_latency", 64'(i), 64'd1);
        exp_hold = 64'({11'd1920, 11'd2000, 8'h00, 8'h00});
        chk("scroll clear", fields(), exp_hold);
        chk("scroll busy3", 64'(busy), 64'd1);
        @(negedge clk100);
        wr_complete = 1'b1;
        @(negedge clk100);
        wr_complete = 1'b0;
        chk("scroll busy_fall", 64'(busy), 64'd0);
        chk("scroll b_ack_once", 64'(b_ack_cnt - snap), 64'd1);

        // Reset while waiting on the engine, then a stale completion.
        @(negedge clk100);
        a_req = 1'b1; a_op = 2'd0; a_begin = 11'd0; a_end = 11'd10; a_data = 8'h11;
        for (i = 0; i < 10; i++) begin
            @(negedge clk100);
            if (a_ack) break;
        end
        chk("rstwait ack_latency", 64'(i), 64'd1);
        a_req = 1'b0;
        @(negedge clk100);
        chk("rstwait busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk100);
        rst = 1'b0;
        snap = start_cnt;
        chk("rstwait outputs", all_outs(), 64'd0);
        wr_complete = 1'b1;
        @(negedge clk100);
        wr_complete = 1'b0;
        @(negedge clk100);
        chk("rstwait late_complete", all_outs(), 64'd0);
        chk("rstwait no_start", 64'(start_cnt - snap), 64'd0);
        exp_hold = '0;
        v = '{1'b0, 2'd0, 11'd300, 11'd400, 8'h2a, 8'h00, 1'b1, 11'd300, 11'd400, 8'h2a, 8'h00};
        run_cmd(v, "post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
